// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
// Holds the requester count, the index width, the FSM state type and the winner search.
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First asserted request scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [IDX_W-1:0] next_winner(input logic [NREQ-1:0]  req,
                                                   input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/arb_grant_decoder.sv
// 2-to-4 decoder with enable: turns the winner index into a one-hot grant.
// Purely combinational, so the grant drops in the same cycle its enable falls.
module arb_grant_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] i_gnt_idx,
  input  logic             i_en,
  output logic [NREQ-1:0]  o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      o_gnt[i_gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// 4-requester round-robin arbiter: registered IDLE/GRANT FSM plus enabled grant decoder.
// Define ARB_TIMEOUT_EN to force a grant off after MAX_HOLD cycles and pulse timeout.
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  // Handshake: req stays high until served; gnt is one-hot for exactly the GRANT cycles;
  // done, a dropped req[gnt_idx] or en=0 ends the grant at the next edge.
  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_timeout;
  logic [IDX_W-1:0] w_winner;
  logic             w_other_release;
  logic             w_force;

  assign w_winner        = next_winner(req, r_ptr);
  assign w_other_release = done | ~req[r_idx] | ~en;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] r_hold;

  assign w_force = (r_hold == HOLD_W'(MAX_HOLD - 1));

  // Idle keeps the counter at zero, which is the clear on entry to GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (r_state == GRANT) begin
      r_hold <= r_hold + HOLD_W'(1);
    end else begin
      r_hold <= '0;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && (|req)) begin
            r_state <= GRANT;
            r_idx   <= w_winner;
            r_ptr   <= w_winner + IDX_W'(1);
          end
        end
        GRANT: begin
          // Going back to IDLE gives the mandatory turnaround cycle between grants.
          if (w_other_release || w_force) begin
            r_state <= IDLE;
          end
          r_timeout <= w_force & ~w_other_release;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state == GRANT);
  assign gnt_idx = r_idx;
  assign timeout = r_timeout;

  arb_grant_decoder u_dec (
    .i_gnt_idx (r_idx),
    .i_en      (en & busy),
    .o_gnt     (gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: table-driven cycle vectors plus hand sequences for
// combinational en drop, reset mid-grant and hold timeout (ARB_TIMEOUT_EN selects branch).
module tb_decoder_rr_arbiter;
  import arb_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           n_checks;
  int           n_pass;

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // scoreboard: pop the oldest expectation and compare against the live outputs
  task automatic check(input string nm);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    got = {gnt, gnt_idx, busy, timeout};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: no expected entry queued, got gnt=%b idx=%0d busy=%b tmo=%b",
               nm, gnt, gnt_idx, busy, timeout);
    end else begin
      exp = exp_q.pop_front();
      if (got === exp) n_pass++;
      else $display("FAIL %s: got gnt=%b idx=%0d busy=%b tmo=%b, want gnt=%b idx=%0d busy=%b tmo=%b",
                    nm, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_now(input logic [W-1:0] exp, input string nm);
    exp_q.push_back(exp);
    check(nm);
  endtask

  // driver: inputs applied at the falling edge, outputs checked 1 time unit after the rise
  task automatic step(input logic e, input logic [3:0] r, input logic d,
                      input logic [W-1:0] exp, input string nm);
    en   = e;
    req  = r;
    done = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(nm);
    @(negedge clk);
  endtask

  function automatic void add(input logic rs, input logic e, input logic [3:0] r, input logic d,
                              input logic [3:0] g, input logic [1:0] ix, input logic b);
    vec_t v;
    v.rst = rs; v.en = e; v.req = r; v.done = d; v.gnt = g; v.idx = ix; v.busy = b;
    vecs.push_back(v);
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    req      = 4'b1111;
    done     = 1'b0;

    // round-robin, release causes, en gating, done in IDLE, late requests
    add(0,1,4'b0100,0, 4'b0100,2'd2,1);
    add(0,1,4'b0100,1, 4'b0000,2'd2,0);
    add(0,1,4'b0000,0, 4'b0000,2'd2,0);
    add(1,1,4'b1111,0, 4'b0001,2'd0,1);
    add(0,1,4'b1111,1, 4'b0000,2'd0,0);
    add(0,1,4'b1111,0, 4'b0010,2'd1,1);
    add(0,1,4'b1111,1, 4'b0000,2'd1,0);
    add(0,1,4'b1111,0, 4'b0100,2'd2,1);
    add(0,1,4'b1111,1, 4'b0000,2'd2,0);
    add(0,1,4'b1111,0, 4'b1000,2'd3,1);
    add(0,1,4'b1111,1, 4'b0000,2'd3,0);
    add(0,1,4'b1111,0, 4'b0001,2'd0,1);
    add(0,1,4'b1111,1, 4'b0000,2'd0,0);
    add(0,1,4'b0010,0, 4'b0010,2'd1,1);
    add(0,1,4'b0000,0, 4'b0000,2'd1,0);
    add(0,1,4'b0011,0, 4'b0001,2'd0,1);
    add(0,1,4'b0011,1, 4'b0000,2'd0,0);
    add(0,1,4'b0010,0, 4'b0010,2'd1,1);
    add(0,0,4'b0010,0, 4'b0000,2'd1,0);
    add(0,0,4'b1111,0, 4'b0000,2'd1,0);
    add(0,1,4'b0010,0, 4'b0010,2'd1,1);
    add(0,1,4'b0000,0, 4'b0000,2'd1,0);
    add(0,1,4'b0000,1, 4'b0000,2'd1,0);
    add(0,1,4'b0100,1, 4'b0100,2'd2,1);
    add(0,1,4'b0100,1, 4'b0000,2'd2,0);
    add(0,1,4'b0001,0, 4'b0001,2'd0,1);
    add(0,1,4'b0011,0, 4'b0001,2'd0,1);
    add(0,1,4'b0010,0, 4'b0000,2'd0,0);
    add(0,1,4'b0010,0, 4'b0010,2'd1,1);
    add(0,1,4'b0010,1, 4'b0000,2'd1,0);

    // reset held with all requests active
    repeat (2) @(negedge clk);
    expect_now({4'b0000, 2'd0, 1'b0, 1'b0}, "reset_state");
    req = 4'b0000;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].en, vecs[i].req, vecs[i].done,
           {vecs[i].gnt, vecs[i].idx, vecs[i].busy, 1'b0}, $sformatf("vec%0d", i));
    end

    // en drop kills gnt in the same cycle, FSM leaves GRANT on the next edge
    do_reset();
    step(1, 4'b0010, 0, {4'b0010, 2'd1, 1'b1, 1'b0}, "en_grant");
    en = 1'b0;
    #1;
    expect_now({4'b0000, 2'd1, 1'b1, 1'b0}, "en_comb_drop");
    step(0, 4'b0010, 0, {4'b0000, 2'd1, 1'b0, 1'b0}, "en_idle");

    // reset mid-grant: outputs clear at once and the pointer restarts at 0
    step(1, 4'b0100, 0, {4'b0100, 2'd2, 1'b1, 1'b0}, "pre_rst_grant");
    rst_n = 1'b0;
    #1;
    expect_now({4'b0000, 2'd0, 1'b0, 1'b0}, "rst_mid_grant");
    #1;
    rst_n = 1'b1;
    step(1, 4'b0000, 0, {4'b0000, 2'd0, 1'b0, 1'b0}, "post_rst_idle");
    step(1, 4'b1010, 0, {4'b0010, 2'd1, 1'b1, 1'b0}, "post_rst_ptr");
    step(1, 4'b1010, 1, {4'b0000, 2'd1, 1'b0, 1'b0}, "post_rst_done");

    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++)
      step(1, 4'b0001, 0, {4'b0001, 2'd0, 1'b1, 1'b0}, $sformatf("hold%0d", k));
    step(1, 4'b0001, 0, {4'b0000, 2'd0, 1'b0, 1'b1}, "timeout_pulse");
    step(1, 4'b0001, 0, {4'b0001, 2'd0, 1'b1, 1'b0}, "regrant");
    step(1, 4'b0001, 0, {4'b0001, 2'd0, 1'b1, 1'b0}, "regrant_hold");
    step(1, 4'b0000, 0, {4'b0000, 2'd0, 1'b0, 1'b0}, "regrant_drop");
`else
    for (int k = 0; k < 22; k++)
      step(1, 4'b0001, 0, {4'b0001, 2'd0, 1'b1, 1'b0}, $sformatf("hold%0d", k));
    step(1, 4'b0000, 0, {4'b0000, 2'd0, 1'b0, 1'b0}, "hold_drop");
`endif

    // final report
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover_queue: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
